// File: rtl/uart_word_tx.sv
// Serializes DATA_WIDTH-bit words as consecutive 8N1 frames, low byte first, through a one-word holding register.
// A load occurs one edge after capture; tx_done pulses on that load, and a word arriving while hold is full and not loading is dropped (sticky overrun).
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  tx_done,
    output logic                  tx_serial,
    output logic                  busy,
    output logic                  overrun
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int TW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [TW-1:0] TMAX      = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [2:0]            bit_idx;
    logic [BW-1:0]         byte_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_full;

    logic bit_end, word_end, load, capture, hold_full_nxt, idle_nxt;

    always_comb begin
        bit_end       = (timer == TMAX);
        word_end      = (state == STOP) && bit_end && (byte_idx == LAST_BYTE);
        load          = hold_full && ((state == IDLE) || word_end);
        // A word arriving on the same edge hold is drained replaces it rather than overrunning.
        capture       = data_in_valid && (!hold_full || load);
        hold_full_nxt = capture || (hold_full && !load);
        idle_nxt      = !load && ((state == IDLE) || word_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tx_done   <= load;
            busy      <= hold_full_nxt || !idle_nxt;
            hold_full <= hold_full_nxt;
            if (capture)
                hold <= data_in;
            if (data_in_valid && !capture)
                overrun <= 1'b1;

            if (load) begin
                state     <= START;
                shreg     <= hold;
                byte_idx  <= '0;
                bit_idx   <= '0;
                timer     <= '0;
                tx_serial <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        timer     <= '0;
                        tx_serial <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            timer     <= '0;
                            bit_idx   <= '0;
                            state     <= DATA;
                            tx_serial <= shreg[0];
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            timer <= '0;
                            // Shifting every data bit leaves the next byte in shreg[7:0].
                            shreg <= shreg >> 1;
                            if (bit_idx == 3'd7) begin
                                state     <= STOP;
                                tx_serial <= 1'b1;
                            end else begin
                                bit_idx   <= bit_idx + 1'b1;
                                tx_serial <= shreg[1];
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            timer <= '0;
                            if (word_end) begin
                                state     <= IDLE;
                                tx_serial <= 1'b1;
                            end else begin
                                byte_idx  <= byte_idx + 1'b1;
                                state     <= START;
                                tx_serial <= 1'b0;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx at 4 clocks per bit: a word-level timing model feeds a scoreboard that a line decoder drains.
module tb_uart_word_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int WORD  = 2 * FRAME;

    logic        clk, rst;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        tx_done, tx_serial, busy, overrun;

    uart_word_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .tx_done(tx_done), .tx_serial(tx_serial), .busy(busy), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] w;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        m_full = 1'b0, m_ovr = 1'b0, exp_done = 1'b0;
    logic [15:0] m_hold = '0;
    int          m_free = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Word-level model: the shifter is free WORD cycles after each load; hold has one slot.
    initial begin
        logic ld;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_full = 1'b0; m_free = 0; m_ovr = 1'b0; exp_done = 1'b0;
                exp_q.delete();
            end else begin
                ld = m_full && (cyc >= m_free);
                exp_done = ld;
                if (ld) begin
                    e.w = m_hold; e.c = cyc;
                    exp_q.push_back(e);
                    m_free = cyc + WORD;
                end
                if (data_in_valid) begin
                    if (!m_full || ld) begin
                        m_hold = data_in;
                        m_full = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end else if (ld) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Line decoder and per-cycle output checks.
    initial begin
        logic        act = 1'b0;
        int          k = 0, byte_n = 0, b;
        logic [7:0]  byte_val = '0;
        logic [15:0] word_val = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0; byte_n = 0;
                chk("rst_tx_serial", int'(tx_serial), 1);
                chk("rst_busy", int'(busy), 0);
                chk("rst_tx_done", int'(tx_done), 0);
                chk("rst_overrun", int'(overrun), 0);
            end else begin
                chk("tx_done", int'(tx_done), int'(exp_done));
                chk("busy", int'(busy), int'(m_full || (cyc < m_free)));
                chk("overrun", int'(overrun), int'(m_ovr));
                if (!act && cyc >= m_free)
                    chk("idle_line", int'(tx_serial), 1);
                if (!act && tx_serial == 1'b0) begin
                    act = 1'b1; k = 0;
                    if (exp_q.size() == 0)
                        chk("frame_unexpected", 1, 0);
                    else
                        chk("start_time", cyc, exp_q[0].c + byte_n * FRAME);
                end
                if (act) begin
                    if (k % CPB == CPB / 2) begin
                        b = k / CPB;
                        if (b == 0)
                            chk("start_bit", int'(tx_serial), 0);
                        else if (b <= 8)
                            byte_val[b-1] = tx_serial;
                        else begin
                            chk("stop_bit", int'(tx_serial), 1);
                            if (byte_n == 0) word_val[7:0] = byte_val;
                            else             word_val[15:8] = byte_val;
                            byte_n++;
                            if (byte_n == 2) begin
                                byte_n = 0;
                                if (exp_q.size() > 0) begin
                                    chk("word_data", int'(word_val), int'(exp_q[0].w));
                                    void'(exp_q.pop_front());
                                end
                            end
                        end
                    end
                    if (k == 9 * CPB + CPB / 2) act = 1'b0;
                    else k++;
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        @(negedge clk);
        data_in = w; data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
    endtask

    task automatic wait_done(output int l);
        int i;
        l = -1;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_done) begin
                l = cyc;
                break;
            end
        end
        if (l < 0) chk("tx_done_timeout", 0, 1);
    endtask

    initial begin
        int l;
        rst = 1'b1; data_in = '0; data_in_valid = 1'b0;
        idle(3);
        rst = 1'b0;

        send(16'hA55A);
        idle(120);

        send(16'h1234);
        wait_done(l);
        send(16'hBEEF);
        idle(200);

        do_reset();
        @(negedge clk); data_in = 16'h0001; data_in_valid = 1'b1;
        @(negedge clk); data_in = 16'h0002;
        @(negedge clk); data_in = 16'h0003;
        @(negedge clk); data_in_valid = 1'b0;
        idle(200);

        do_reset();
        send(16'hCAFE);
        wait_done(l);
        send(16'h5A0F);
        while (cyc < l + WORD - 1) @(negedge clk);
        data_in = 16'h9C3E; data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        idle(300);

        do_reset();
        send(16'h7E81);
        wait_done(l);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_tx_serial", int'(tx_serial), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_tx_done", int'(tx_done), 0);
        idle(2);
        rst = 1'b0;
        send(16'h00FF);
        idle(120);

        do_reset();
        idle(200);

        repeat (30) begin
            idle($urandom_range(0, 90));
            send(16'($urandom));
        end

        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !m_full && cyc >= m_free) break;
            @(negedge clk);
        end
        idle(4);
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
